mem_responder: RTL and testbench

- Word-addressed memory slave that answers the CPU-side memory request interface (enable/read/write/address/in → out/ready).
- Sits at the responder end of the IOM port, or behind a cache's Sys port, and inserts a configurable number of wait states.
- `ready` is the stall signal: the initiator's pipeline advances only while `ready` = 1.
- Holds a local word array and completes every accepted request after a fixed latency.

---
 rtl/mem_if_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory responder: FSM states, request opcodes
// and the default wait-state count.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_t;

    localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request bus: the initiator drives the request, the
// responder returns read data, the ready/stall flag and the range error.
interface mem_responder_if;

    logic        enable;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic        addr_error;

    modport master (
        output enable, read, write, address, data_in,
        input  data_out, ready, addr_error
    );

    modport slave (
        input  enable, read, write, address, data_in,
        output data_out, ready, addr_error
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word RAM with a registered read port; the word at index is
// presented on rdata one edge after index is applied.
module mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // NOTE: no reset on the array itself so it maps onto block RAM; its
    // contents are undefined until written.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory slave: accepts one request at a time, stalls the
// initiator for LATENCY wait cycles, then completes with a one-cycle DONE.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = DEFAULT_LATENCY,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic clock,
    input  logic reset,
    mem_responder_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                state;
    logic [3:0]            counter;
    op_t                   op;
    logic [31:0]           addr_q;
    logic [31:0]           data_q;
    logic [31:0]           data_out_q;
    logic                  addr_error_q;

    logic [DEPTH_LOG2-1:0] index;
    logic [DEPTH_LOG2-1:0] ram_index;
    logic                  in_range;
    logic                  execute;
    logic                  we;
    logic [31:0]           rdata;

    assign index    = addr_q[DEPTH_LOG2+1:2];
    assign in_range = (addr_q[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign execute  = (state == WAIT) && (counter == 4'd0);
    assign we       = execute && (op == WRITE) && in_range;

    // The RAM reads the live address while idle so that with LATENCY = 1 the
    // word is already on rdata at the execute edge; afterwards it follows the
    // captured index, which is stable for the rest of the request.
    assign ram_index = (state == IDLE) ? bus.address[DEPTH_LOG2+1:2] : index;

    assign bus.ready      = ((state == IDLE) && !bus.enable) || (state == DONE);
    assign bus.data_out   = data_out_q;
    assign bus.addr_error = addr_error_q;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (we),
        .index (ram_index),
        .wdata (data_q),
        .rdata (rdata)
    );

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            op           <= READ;
            addr_q       <= '0;
            data_q       <= '0;
            data_out_q   <= '0;
            addr_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        op      <= bus.write ? WRITE : READ;
                        addr_q  <= bus.address;
                        data_q  <= bus.data_in;
                        counter <= LAT_M1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (counter == 4'd0) begin
                        if (op == READ) begin
                            data_out_q <= in_range ? rdata : 32'h0;
                        end
                        addr_error_q <= !in_range;
                        state        <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    addr_error_q <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance for the main
// sequence and one LATENCY=1 instance for the short-latency sweep.
module tb_mem_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_done_a = 0;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(
        .DEPTH_LOG2 (10),
        .LATENCY    (2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mem_responder #(
        .DEPTH_LOG2 (10),
        .LATENCY    (1),
        .BASE_ADDR  (32'h0000_0000)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clock = ~clock;

    // Completed writes on instance A: a DONE cycle with a write request present.
    always @(negedge clock) begin
        if (bus_a.enable === 1'b1 && bus_a.ready === 1'b1 && bus_a.write === 1'b1)
            wr_done_a++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit on_b, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data);
        if (on_b) begin
            bus_b.enable = 1'b1; bus_b.write = wr; bus_b.read = rd;
            bus_b.address = addr; bus_b.data_in = data;
        end else begin
            bus_a.enable = 1'b1; bus_a.write = wr; bus_a.read = rd;
            bus_a.address = addr; bus_a.data_in = data;
        end
    endtask

    // Counts stalled cycles until ready is seen; returns in the DONE cycle.
    task automatic wait_ready(input bit on_b, output int low,
                              output logic [31:0] dout, output logic err);
        bit   seen = 1'b0;
        logic r;
        low  = 0;
        dout = 'x;
        err  = 1'bx;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            r = on_b ? bus_b.ready : bus_a.ready;
            if (r === 1'b1) begin
                seen = 1'b1;
                dout = on_b ? bus_b.data_out : bus_a.data_out;
                err  = on_b ? bus_b.addr_error : bus_a.addr_error;
            end else begin
                low++;
                step();
            end
        end
        check("handshake_completes", 32'(seen), 32'd1);
    endtask

    task automatic request(input bit on_b, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int low, output logic [31:0] dout, output logic err);
        drive(on_b, wr, rd, addr, data);
        wait_ready(on_b, low, dout, err);
    endtask

    task automatic release_bus(input bit on_b);
        if (on_b) begin
            bus_b.enable = 1'b0; bus_b.write = 1'b0; bus_b.read = 1'b0;
        end else begin
            bus_a.enable = 1'b0; bus_a.write = 1'b0; bus_a.read = 1'b0;
        end
        step();
    endtask

    initial begin
        int          low;
        logic [31:0] dout;
        logic        err;
        int          wr_base;

        bus_a.enable = 0; bus_a.read = 0; bus_a.write = 0; bus_a.address = 0; bus_a.data_in = 0;
        bus_b.enable = 0; bus_b.read = 0; bus_b.write = 0; bus_b.address = 0; bus_b.data_in = 0;

        // Asynchronous reset before the first clock edge
        #1 reset = 1'b0;
        #2;
        check("rst_ready_a", 32'(bus_a.ready), 32'd1);
        check("rst_data_out_a", bus_a.data_out, 32'h0);
        check("rst_addr_error_a", 32'(bus_a.addr_error), 32'd0);
        check("rst_ready_b", 32'(bus_b.ready), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("idle_ready_1", 32'(bus_a.ready), 32'd1);
        step();
        check("idle_ready_2", 32'(bus_a.ready), 32'd1);

        // Write then read, LATENCY = 2
        request(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, low, dout, err);
        check("wr10_stall_cycles", 32'(low), 32'd3);
        check("wr10_addr_error", 32'(err), 32'd0);
        release_bus(0);
        #1;
        check("wr10_idle_ready", 32'(bus_a.ready), 32'd1);

        request(0, 1'b0, 1'b1, 32'h10, 32'h0, low, dout, err);
        check("rd10_stall_cycles", 32'(low), 32'd3);
        check("rd10_data_done", dout, 32'hDEAD_BEEF);
        check("rd10_addr_error", 32'(err), 32'd0);
        release_bus(0);
        check("rd10_data_held_1", bus_a.data_out, 32'hDEAD_BEEF);
        step();
        check("rd10_data_held_2", bus_a.data_out, 32'hDEAD_BEEF);

        // Out of range: word 0 aliases 32'h1000 by index but must be untouched
        request(0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, low, dout, err);
        release_bus(0);
        request(0, 1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, low, dout, err);
        check("oor_wr_addr_error", 32'(err), 32'd1);
        release_bus(0);
        check("oor_wr_error_cleared", 32'(bus_a.addr_error), 32'd0);
        request(0, 1'b0, 1'b1, 32'h0, 32'h0, low, dout, err);
        check("word0_unchanged", dout, 32'h0BAD_F00D);
        release_bus(0);
        request(0, 1'b0, 1'b1, 32'h1000, 32'h0, low, dout, err);
        check("oor_rd_data", dout, 32'h0);
        check("oor_rd_addr_error", 32'(err), 32'd1);
        release_bus(0);

        // Back-to-back: enable stays high through DONE into the next request
        wr_base = wr_done_a;
        request(0, 1'b1, 1'b0, 32'h20, 32'hA5A5_A5A5, low, dout, err);
        check("b2b_wr_stall_cycles", 32'(low), 32'd3);
        @(negedge clock);
        #1;
        bus_a.write = 1'b0;
        bus_a.read  = 1'b1;
        step();
        wait_ready(0, low, dout, err);
        check("b2b_rd_stall_cycles", 32'(low), 32'd3);
        check("b2b_rd_data", dout, 32'hA5A5_A5A5);
        check("b2b_write_count", 32'(wr_done_a - wr_base), 32'd1);
        release_bus(0);

        // Write priority and capture of address/data at acceptance
        request(0, 1'b1, 1'b0, 32'h30, 32'h3030_3030, low, dout, err);
        release_bus(0);
        drive(0, 1'b1, 1'b1, 32'h8, 32'h0000_1234);
        step();
        bus_a.address = 32'h30;
        bus_a.data_in = 32'hFFFF_0000;
        bus_a.write   = 1'b0;
        bus_a.read    = 1'b1;
        wait_ready(0, low, dout, err);
        check("cap_wait_cycles", 32'(low), 32'd2);
        release_bus(0);
        request(0, 1'b0, 1'b1, 32'h8, 32'h0, low, dout, err);
        check("cap_rd8", dout, 32'h0000_1234);
        release_bus(0);
        request(0, 1'b0, 1'b1, 32'h30, 32'h0, low, dout, err);
        check("cap_rd30_untouched", dout, 32'h3030_3030);
        release_bus(0);

        // Reset in WAIT just before the execute edge abandons the write
        request(0, 1'b1, 1'b0, 32'h4, 32'h1111_1111, low, dout, err);
        release_bus(0);
        drive(0, 1'b1, 1'b0, 32'h4, 32'h2222_2222);
        step();
        step();
        #1 reset = 1'b0;
        #1;
        check("wait_rst_ready_en1", 32'(bus_a.ready), 32'd0);
        check("wait_rst_data_out", bus_a.data_out, 32'h0);
        bus_a.enable = 1'b0;
        bus_a.write  = 1'b0;
        #1;
        check("wait_rst_ready_en0", 32'(bus_a.ready), 32'd1);
        #1 reset = 1'b1;
        step();
        step();
        request(0, 1'b0, 1'b1, 32'h4, 32'h0, low, dout, err);
        check("wait_rst_prior_value", dout, 32'h1111_1111);
        release_bus(0);

        // LATENCY = 1 instance
        request(1, 1'b1, 1'b0, 32'h40, 32'hCAFE_0001, low, dout, err);
        check("lat1_wr_stall_cycles", 32'(low), 32'd2);
        check("lat1_wr_addr_error", 32'(err), 32'd0);
        release_bus(1);
        request(1, 1'b0, 1'b1, 32'h40, 32'h0, low, dout, err);
        check("lat1_rd_stall_cycles", 32'(low), 32'd2);
        check("lat1_rd_data", dout, 32'hCAFE_0001);
        release_bus(1);
        request(1, 1'b0, 1'b1, 32'h2000, 32'h0, low, dout, err);
        check("lat1_oor_data", dout, 32'h0);
        check("lat1_oor_addr_error", 32'(err), 32'd1);
        release_bus(1);
        check("lat1_oor_error_cleared", 32'(bus_b.addr_error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
